// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem reads, prefetch FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushes counters.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_AW    = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          imem_req,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          consume_ready,
  output logic                          push_ops,
  output logic [31:0]                   opcode,
  output logic [31:0]                   fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_flushes
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] PC_RST = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        issue_pc_q, issue_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        data_q  [FIFO_DEPTH];
  logic [31:0]        pcbuf_q [FIFO_DEPTH];
  logic [OCC_W-1:0]   occupancy;
  logic               empty, credit_ok, wr_en;

  // Credit covers both buffered words and the one response that may be on its way.
  assign occupancy = {1'b0, count_q} + OCC_W'(inflight_q);
  assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);
  assign empty     = (count_q == '0);
  assign wr_en     = inflight_q && !redirect_valid;

  assign push_ops   = !empty && consume_ready && !redirect_valid;
  assign imem_req   = (state_q == RUN) && enable && !redirect_valid && credit_ok;
  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign opcode     = empty ? NOP : data_q[rd_ptr_q];
  assign fetch_pc   = empty ? 32'h0 : pcbuf_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (!enable && !inflight_q) state_d = IDLE;
        else if (!credit_ok)        state_d = STALL;
      end
      STALL: begin
        if (!enable && !inflight_q) state_d = IDLE;
        else if (credit_ok)         state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect overrides issue, response write and pop in the same cycle.
  always_comb begin
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = imem_req;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + 32'd4;
        issue_pc_d = pc_q;
      end
      if (wr_en)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_ops) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(push_ops);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_RST;
      issue_pc_q <= 32'h0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_ptr_q]  <= imem_rdata;
      pcbuf_q[wr_ptr_q] <= issue_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_flushes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_flushes_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(push_ops);
      perf_flushes_q <= perf_flushes_q + 32'(redirect_valid);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed scenarios plus randomized traffic checked
// against an in-order PC stream model and the delivery rules.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic [31:0]       imem_rdata;
  logic              consume_ready;
  logic              push_ops;
  logic [31:0]       opcode;
  logic [31:0]       fetch_pc;
  logic [2:0]        fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_flushes;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .IMEM_AW(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .consume_ready(consume_ready), .push_ops(push_ops), .opcode(opcode),
    .fetch_pc(fetch_pc), .fifo_count(fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'hA000_0000 + 32'(pc[AW+1:2]);
  endfunction

  // Memory: word n reads 0xA000_0000+n one cycle after a request, garbage otherwise.
  always @(posedge clk)
    imem_rdata <= imem_req ? (32'hA000_0000 + 32'(imem_addr)) : $urandom();

  // Reference: delivered words must follow the PC stream from the last reset/redirect.
  logic [31:0] exp_pc;
  logic        prev_redirect;
  int          pushes;
  int          flushes;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc        = RESET_PC & 32'hFFFF_FFFC;
      prev_redirect = 1'b0;
      pushes        = 0;
      flushes       = 0;
    end else begin
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, 32'(pushes));
      chk("perf_flushes", perf_flushes, 32'(flushes));
`endif
      chk("push_rule", 32'(push_ops), 32'((fifo_count != 0) && consume_ready && !redirect_valid));
      chk("count_bound", 32'(fifo_count > 3'(DEPTH)), 32'h0);
      if (fifo_count == 0) begin
        chk("empty_opcode", opcode, 32'h0000_0013);
        chk("empty_pc", fetch_pc, 32'h0);
      end
      if (redirect_valid) chk("req_on_redirect", 32'(imem_req), 32'h0);
      if (prev_redirect)  chk("flush_count", 32'(fifo_count), 32'h0);
      if (push_ops) begin
        chk("stream_pc", fetch_pc, exp_pc);
        chk("stream_op", opcode, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pushes++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        flushes++;
      end
      prev_redirect = redirect_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_push"},  32'(push_ops), 32'h0);
    chk({tag, "_op"},    opcode, 32'h0000_0013);
    chk({tag, "_pc"},    fetch_pc, 32'h0);
    chk({tag, "_count"}, 32'(fifo_count), 32'h0);
  endtask

  task automatic do_reset(input logic en, input logic cr);
    @(posedge clk);
    #3 reset = 1'b1;
    redirect_valid = 1'b0;
    enable = 1'b0;
    consume_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    enable = en;
    consume_ready = cr;
  endtask

  task automatic wait_push(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (push_ops) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    bit hit;
    logic pr;
    int p0;

    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; consume_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0; enable = 1'b1; consume_ready = 1'b1;

    // Streaming from RESET_PC with no bubbles once started.
    wait_push(12, got);
    chk("t1_timeout", 32'(got), 32'h1);
    chk("t1_first_pc", fetch_pc, 32'h0000_0100);
    chk("t1_first_op", opcode, 32'hA000_0040);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_no_bubble", 32'(push_ops), 32'h1);
    end

    // Consumer stall fills the FIFO and stops issue; release drains in order.
    @(posedge clk); #1 consume_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t2_full", 32'(fifo_count), 32'(DEPTH));
    chk("t2_no_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1 consume_ready = 1'b1;
    p0 = pushes;
    repeat (16) @(posedge clk);
    chk("t2_resume", 32'(pushes - p0 >= 12), 32'h1);

    // Redirect with 3 buffered and 1 in flight.
    do_reset(1'b1, 1'b0);
    hit = 1'b0;
    pr = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (imem_req && (32'(fifo_count) + 32'(pr)) == 32'd3) hit = 1'b1;
      pr = imem_req;
    end
    chk("t3_setup", 32'(hit), 32'h1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; consume_ready = 1'b1;
    @(negedge clk);
    chk("t3_buffered", 32'(fifo_count), 32'h3);
    chk("t4_no_push", 32'(push_ops), 32'h0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_flushed", 32'(fifo_count), 32'h0);
    wait_push(12, got);
    chk("t3_timeout", 32'(got), 32'h1);
    chk("t3_pc", fetch_pc, 32'h0000_0200);
    chk("t3_op", opcode, 32'hA000_0080);

    // Asynchronous reset in the middle of a stream.
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("t5_rst");
    @(posedge clk); #1 reset = 1'b0;
    wait_push(12, got);
    chk("t5_timeout", 32'(got), 32'h1);
    chk("t5_pc", fetch_pc, RESET_PC);

    // Redirect near the top of the address space wraps to zero.
    do_reset(1'b0, 1'b1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; enable = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] wpc;
      wpc = 32'hFFFF_FFF8 + 32'(k * 4);
      wait_push(12, got);
      chk("t6_timeout", 32'(got), 32'h1);
      chk("t6_pc", fetch_pc, wpc);
      chk("t6_op", opcode, mem_word(wpc));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_fetched", perf_fetched, 32'h2);
    chk("t6_perf_flushes", perf_flushes, 32'h1);
`endif

    // Randomized traffic with occasional redirects and asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      enable         = ($urandom_range(0, 7) != 0);
      consume_ready  = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom();
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("rnd_rst");
        @(posedge clk); #1 reset = 1'b0;
      end
    end

    @(posedge clk); #1 enable = 1'b0; redirect_valid = 1'b0;
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
